// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_pkg
//  Description : Op encodings, identity bit and lane-geometry helpers shared
//                by the reduction pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package reduce_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND  = 2'b00;
   localparam op_t OP_OR   = 2'b01;
   localparam op_t OP_XOR  = 2'b10;
   localparam op_t OP_NAND = 2'b11;

   // NAND reduces as AND inside the tree, so it shares AND's identity.
   function automatic logic identity_bit(input op_t op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

   // Number of lanes entering stage k (k = 0 is the raw input).
   function automatic int lanes_at(input int width, input int chunk, input int k);
      int lanes;
      lanes = width;
      for (int i = 0; i < k; i++) begin
         lanes = (lanes + chunk - 1) / chunk;
      end
      return lanes;
   endfunction

   // Stages needed to collapse width lanes to one: ceil(log_chunk(width)).
   function automatic int calc_lat(input int width, input int chunk);
      int lanes;
      int lat;
      lanes = width;
      lat   = 0;
      while (lanes > 1) begin
         lanes = (lanes + chunk - 1) / chunk;
         lat   = lat + 1;
      end
      return lat;
   endfunction

   // Bit offset of stage k's lanes within the flattened inter-stage bus.
   function automatic int lane_offset(input int width, input int chunk, input int k);
      int off;
      off = 0;
      for (int i = 0; i < k; i++) begin
         off = off + lanes_at(width, chunk, i);
      end
      return off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_stage.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_stage
//  Description : One reduction stage: folds groups of CHUNK lanes into one
//                registered lane each, carrying op and valid alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module reduce_stage
   import reduce_pkg::*;
#(
   parameter  int IN_LANES  = 8,
   parameter  int CHUNK     = 4,
   localparam int OUT_LANES = (IN_LANES + CHUNK - 1) / CHUNK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic                 i_valid,
   input  logic [IN_LANES-1:0]  i_lanes,
   input  op_t                  i_op,
   output logic                 o_valid,
   output logic [OUT_LANES-1:0] o_lanes,
   output op_t                  o_op
);

   localparam int PAD_W = OUT_LANES * CHUNK;

   logic [PAD_W-1:0]     w_padded;
   logic [OUT_LANES-1:0] w_red;

   logic                 r_valid;
   logic [OUT_LANES-1:0] r_lanes;
   op_t                  r_op;

   // Lanes past IN_LANES take the identity so a partial group is unaffected.
   always_comb begin
      w_padded                 = {PAD_W{identity_bit(i_op)}};
      w_padded[IN_LANES-1:0]   = i_lanes;
   end

   for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
      logic [CHUNK-1:0] w_grp;
      assign w_grp    = w_padded[j*CHUNK +: CHUNK];
      assign w_red[j] = (i_op == OP_OR)  ? (|w_grp) :
                        (i_op == OP_XOR) ? (^w_grp) :
                                           (&w_grp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_lanes <= '0;
         r_op    <= OP_AND;
      end else if (i_en) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_lanes <= w_red;
            r_op    <= i_op;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_lanes = r_lanes;
   assign o_op    = r_op;

endmodule
`default_nettype wire

// File: rtl/reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_pipe
//  Description : Pipelined AND/OR/XOR/NAND bit reduction with valid/ready
//                flow control and a completed-result counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module reduce_pipe
   import reduce_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             global_reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [1:0]       out_op,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] result_cnt
);

   localparam int LAT   = calc_lat(WIDTH, CHUNK);
   localparam int BUS_W = lane_offset(WIDTH, CHUNK, LAT + 1);

   // All stage lanes live in one flat bus; stage k reads its slice and
   // writes the next, ending in a single lane at the top bit.
   logic [BUS_W-1:0]     w_bus;
   logic [LAT:0]         w_valid;
   logic [LAT:0][1:0]    w_op;
   logic                 w_stall;
   logic                 w_handshake;
   logic [CNT_W-1:0]     r_cnt;

   assign w_bus[WIDTH-1:0] = in_data;
   assign w_valid[0]       = in_valid;
   assign w_op[0]          = in_op;

   for (genvar k = 0; k < LAT; k++) begin : g_stage
      localparam int IN_L    = lanes_at(WIDTH, CHUNK, k);
      localparam int OUT_L   = lanes_at(WIDTH, CHUNK, k + 1);
      localparam int IN_OFF  = lane_offset(WIDTH, CHUNK, k);
      localparam int OUT_OFF = lane_offset(WIDTH, CHUNK, k + 1);

      reduce_stage #(
         .IN_LANES (IN_L),
         .CHUNK    (CHUNK)
      ) u_stage (
         .clk     (clk),
         .rst_n   (global_reset_n),
         .i_en    (in_ready),
         .i_valid (w_valid[k]),
         .i_lanes (w_bus[IN_OFF +: IN_L]),
         .i_op    (w_op[k]),
         .o_valid (w_valid[k+1]),
         .o_lanes (w_bus[OUT_OFF +: OUT_L]),
         .o_op    (w_op[k+1])
      );
   end

   assign out_valid   = w_valid[LAT];
   assign out_op      = w_op[LAT];
   assign out_bit     = w_bus[BUS_W-1] ^ (w_op[LAT] == OP_NAND);

   assign w_stall     = out_valid & ~out_ready;
   assign in_ready    = ~w_stall;
   assign w_handshake = out_valid & out_ready;

   always_ff @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_handshake) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign result_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/reduce_pipe.md
REDUCE_PIPE -- requirements
Module: reduce_pipe

Interface
REQ-001 SHALL take parameter WIDTH, default 8, as the number of data input bits (legal range 2..640).
REQ-002 SHALL take parameter CHUNK, default 4, as the operands reduced per pipeline stage (legal range 2..8).
REQ-003 SHALL take parameter CNT_W, default 16, as the width of the result counter.
REQ-004 SHALL derive localparam LAT = ceil(log_CHUNK(WIDTH)), the pipeline depth (WIDTH=8, CHUNK=4 gives LAT=2).
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port global_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the input beat.
REQ-009 SHALL have port in_data, input, WIDTH bits: operand bits.
REQ-010 SHALL have port in_op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 SHALL have port out_bit, output, 1 bit: the reduction result.
REQ-014 SHALL have port out_op, output, 2 bits: the op that travelled with the result.
REQ-015 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the result counter.
REQ-016 SHALL have port result_cnt, output, CNT_W bits: count of completed output handshakes.

Function
REQ-017 SHALL accept an input beat on a clk edge where in_valid and in_ready are both 1.
REQ-018 SHALL deliver an output beat on a clk edge where out_valid and out_ready are both 1.
REQ-019 SHALL drive stall = out_valid AND NOT out_ready, and in_ready = NOT stall (combinational).
REQ-020 SHALL hold every pipeline stage (data, op, valid) while stall is 1.
REQ-021 SHALL, when not stalled, advance every stage by one each cycle; a stage with no accepted beat loads valid=0.
REQ-022 SHALL present the result of a beat accepted at edge N on out_bit at edge N+LAT when no stall occurs; each stall cycle adds one cycle.
REQ-023 SHALL have stage k reduce groups of CHUNK lanes from stage k-1; the final stage produces one lane.
REQ-024 SHALL pad partial groups with the op identity: 1 for AND/NAND, 0 for OR/XOR.
REQ-025 SHALL apply NAND inversion only at the output of the final stage.
REQ-026 SHALL carry in_op through every stage with its data, so ops may change every beat with no bubble.
REQ-027 SHALL sustain full throughput: one accept per cycle while out_ready=1.
REQ-028 SHALL increment result_cnt by 1 per output handshake and wrap from 2^CNT_W-1 to 0.
REQ-029 SHALL give cnt_clr priority when cnt_clr and an output handshake coincide: result_cnt becomes 0.
REQ-030 SHALL leave in_valid=0 with in_ready=1 without side effects.
REQ-031 SHALL require out_bit and out_op to stay stable while out_valid=1 and out_ready=0.

Reset
REQ-032 SHALL, on global_reset_n=0, immediately clear all stage valids, out_valid, out_bit, out_op and result_cnt to 0.
REQ-033 SHALL discard in-flight beats when reset is asserted mid-operation; no result emerges after reset release.
REQ-034 SHALL accept a beat on the first clk edge after reset release (in_ready=1 out of reset).

Structure
REQ-035 SHALL place the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND) and an identity-bit function in shared package reduce_pkg.
REQ-036 SHALL implement one stage as sub-module reduce_stage (parameters IN_LANES and CHUNK; registered lanes, op and valid; hold input), instantiated LAT times via generate.
REQ-037 SHALL keep the target implementation within 120-400 lines of RTL.

Verification
REQ-038 SHALL check a back-to-back walk with WIDTH=8, CHUNK=4, out_ready=1 and op AND, driving in_data 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF on consecutive cycles -> out_bit 0,0,0,0,0,0,0,0,1 starting 2 cycles after the first accept.
REQ-039 SHALL check mixed ops on data 0xA5 in order AND, OR, XOR, NAND -> out_bit 0,1,0,1 with matching out_op.
REQ-040 SHALL check backpressure: stream 4 beats, hold out_ready=0 for 3 cycles -> in_ready=0 for those cycles, out_bit/out_op stable, no beat lost or duplicated, result_cnt=4.
REQ-041 SHALL check padding with WIDTH=5 and CHUNK=4: data 0x1F AND -> 1; 0x10 OR -> 1; 0x00 XOR -> 0.
REQ-042 SHALL check reset mid-stream: assert global_reset_n between cycles with 2 beats in flight -> out_valid=0 at once and no output after release.
REQ-043 SHALL check counter behaviour with CNT_W=4: 17 handshakes -> result_cnt=1; cnt_clr coinciding with a handshake -> 0.
